mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 128-bit slow-memory port between the instruction cache and the data cache (each a `cache` instance) in the processor top level. It grants one cache at a time and forwards that cache's request to memory. It routes `mem_ready` back only to the granted cache and holds the grant until the memory transaction completes. Per-port transaction counters are provided for performance debug.

## Interface
Parameters:
- `CNT_W`, 16, width of the per-port transaction counters.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `proc_reset`  input  1  asynchronous, active-high reset.
- `i_read`, `i_write`  input  1 each  I-cache memory request.
- `i_addr`  input  28  I-cache line address.
- `i_wdata`  input  128  I-cache write line; I-cache normally never writes, but the port is supported.
- `i_rdata`  output  128  read data to the I-cache.
- `i_ready`  output  1  completion pulse to the I-cache.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`  same as the `i_*` ports, for the D-cache.
- `mem_read`, `mem_write`  output  1 each  memory request.
- `mem_addr`  output  28  memory line address.
- `mem_wdata`  output  128  memory write line.
- `mem_rdata`  input  128  memory read line.
- `mem_ready`  input  1  one-cycle memory completion pulse.
- `i_cnt`, `d_cnt`  output  CNT_W  completed transactions per port, saturating.

## Operation
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - A port has a request when `x_req = x_read | x_write`.
  - Only I requesting → GNT_I. Only D requesting → GNT_D. No request → stay in IDLE.
  - Both requesting → winner is set by the arbitration policy (see Configuration).
- GNT_x:
  - `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` are a combinational mux of the granted port's inputs.
  - Caches hold their request stable until ready, so no request latching is needed.
  - `x_ready = mem_ready` for the granted port only. The other port's ready is 0.
  - On `mem_ready` → IDLE, and the granted port's counter increments.
  - Protocol violation: if the granted port drops both read and write before `mem_ready` → IDLE. No counter increment and no ready pulse.
- Outside a grant (IDLE): `mem_read = mem_write = 0`, and `mem_addr` and `mem_wdata` are 0.
- `i_rdata = d_rdata = mem_rdata` at all times (broadcast). Only the ready pulse qualifies the data.
- A port is never granted while its request is low.
- A read and a write asserted together are forwarded unchanged; this is the caches' responsibility.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - State IDLE.
  - `mem_read`, `mem_write`, `i_ready`, `d_ready` = 0.
  - `mem_addr`, `mem_wdata` = 0.
  - `i_cnt`, `d_cnt` = 0.
  - Round-robin pointer set so that I has priority first.
- Grant latency: a request seen in IDLE at edge N produces the granted state and a memory request in cycle N+1. The arbitration overhead is exactly 1 cycle per transaction.
- A transaction ends on the edge where `mem_ready` is sampled high. The cycle after that is always IDLE, so back-to-back transactions cost memory latency + 1 cycle each.
- A write-back followed by an allocate from the same cache is two separate grants. The other cache may win between them.
- `proc_reset` asserted mid-transaction:
  - State goes to IDLE immediately (asynchronously) and `mem_read`/`mem_write` drop at once.
  - A `mem_ready` pulse arriving during or after reset in IDLE is ignored.
- `mem_ready` while in IDLE is ignored and produces no ready pulse.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration.
  - A 1-bit pointer flips to the other port whenever a grant completes with `mem_ready`.
  - On a tie, the port the pointer indicates wins.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority, D-cache always wins a tie.
  - No pointer register exists.

## Test plan
- Single I read, memory latency 5 cycles, addr 0x0000010 → `mem_read=1`, `mem_addr=0x0000010` from cycle 1. `i_ready` pulses 1 cycle together with `mem_ready`. `i_rdata` carries the line. `i_cnt=1`, `d_cnt=0`. `d_ready` stays 0.
- I and D both request reads in the same cycle, repeated 4 times:
  - Without the macro: D is granted first every time.
  - With the macro: grants alternate I, D, I, D.
  - Exactly one IDLE cycle between grants.
- D-cache write-back (`d_write`, addr 0x0000020, wdata 0x1234…) followed by a read from the same cache → `mem_write` then `mem_read` as two grants. `mem_wdata` matches exactly during the write. `d_cnt=2`.
- `proc_reset` pulsed in the third cycle of a GNT_D read → `mem_read` drops at once and state is IDLE. A later `mem_ready` gives no `d_ready`. The counters read 0.
- Granted I-cache drops `i_read` before ready → FSM returns to IDLE, `i_cnt` unchanged. A pending D request is granted next.
- `CNT_W=2`, 5 completed D transactions → `d_cnt` saturates at 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared 128-bit memory port to the I-cache or the D-cache, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the D-cache wins a tie.
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    input  logic             i_read,
    input  logic             i_write,
    input  logic [27:0]      i_addr,
    input  logic [127:0]     i_wdata,
    output logic [127:0]     i_rdata,
    output logic             i_ready,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [27:0]      d_addr,
    input  logic [127:0]     d_wdata,
    output logic [127:0]     d_rdata,
    output logic             d_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic [27:0]      mem_addr,
    output logic [127:0]     mem_wdata,
    input  logic [127:0]     mem_rdata,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] d_cnt
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    state_t state, state_nxt;
    logic i_req, d_req, gnt_i, gnt_d, tie_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    assign gnt_i = state == GNT_I;
    assign gnt_d = state == GNT_D;

`ifdef MEM_ARB_RR_EN
    // Pointer high means the D-cache wins the next tie; it moves away from whoever just completed.
    logic rr_d;
    always_ff @(posedge clk or posedge proc_reset)
        if (proc_reset) rr_d <= 1'b0;
        else if ((gnt_i || gnt_d) && mem_ready) rr_d <= gnt_i;
    assign tie_d = rr_d;
`else
    assign tie_d = 1'b1;
`endif

    always_ff @(posedge clk or posedge proc_reset)
        if (proc_reset) state <= IDLE;
        else state <= state_nxt;

    // A granted port that drops its request is released without a ready pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (i_req && d_req) ? (tie_d ? GNT_D : GNT_I) :
                                 i_req ? GNT_I : d_req ? GNT_D : IDLE;
            GNT_I:   state_nxt = (mem_ready || !i_req) ? IDLE : GNT_I;
            GNT_D:   state_nxt = (mem_ready || !d_req) ? IDLE : GNT_D;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (gnt_i & i_read) | (gnt_d & d_read);
        mem_write = (gnt_i & i_write) | (gnt_d & d_write);
        mem_addr  = gnt_i ? i_addr : gnt_d ? d_addr : '0;
        mem_wdata = gnt_i ? i_wdata : gnt_d ? d_wdata : '0;
        i_ready   = gnt_i & mem_ready;
        d_ready   = gnt_d & mem_ready;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
    end

    always_ff @(posedge clk or posedge proc_reset)
        if (proc_reset) begin
            i_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (i_ready && i_cnt != '1) i_cnt <= i_cnt + 1'b1;
            if (d_ready && d_cnt != '1) d_cnt <= d_cnt + 1'b1;
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter, counters built 2 bits wide to reach saturation.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic proc_reset = 1'b1;
    logic i_read = 0, i_write = 0, d_read = 0, d_write = 0, mem_ready = 0;
    logic [27:0] i_addr = '0, d_addr = '0;
    logic [127:0] i_wdata = '0, d_wdata = '0, mem_rdata = '0;
    logic [127:0] i_rdata, d_rdata, mem_wdata;
    logic [27:0] mem_addr;
    logic i_ready, d_ready, mem_read, mem_write;
    logic [1:0] i_cnt, d_cnt;
    int checks = 0, failures = 0;

    mem_arbiter #(.CNT_W(2)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .i_cnt(i_cnt), .d_cnt(d_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
    endtask

    task automatic test_reset();
        rst_pulse();
        checks++;
        if ({mem_read, mem_write, i_ready, d_ready} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%b wr=%b ir=%b dr=%b addr=%h, want all 0",
                     mem_read, mem_write, i_ready, d_ready, mem_addr);
        end
        checks++;
        if (i_cnt !== 2'd0 || d_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_counters: got i=%0d d=%0d, want 0 0", i_cnt, d_cnt);
        end
    endtask

    task automatic test_single_read();
        rst_pulse();
        i_read = 1'b1;
        i_addr = 28'h0000010;
        mem_rdata = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        checks++;
        if (mem_read !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_first: got mem_read=%b, want 0", mem_read);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
            failures++;
            $display("FAIL single_grant: got rd=%b wr=%b addr=%h, want 1 0 0000010", mem_read, mem_write, mem_addr);
        end
        repeat (3) tick();
        checks++;
        if (mem_read !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: got rd=%b i_ready=%b, want 1 0", mem_read, i_ready);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa) begin
            failures++;
            $display("FAIL single_ready: got ir=%b dr=%b rdata=%h, want 1 0 dead...aaaa", i_ready, d_ready, i_rdata);
        end
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0;
        checks++;
        if (mem_read !== 1'b0 || i_cnt !== 2'd1 || d_cnt !== 2'd0) begin
            failures++;
            $display("FAIL single_done: got rd=%b i_cnt=%0d d_cnt=%0d, want 0 1 0", mem_read, i_cnt, d_cnt);
        end
    endtask

    task automatic test_tie();
        logic first_i;
`ifdef MEM_ARB_RR_EN
        first_i = 1'b1;
`else
        first_i = 1'b0;
`endif
        rst_pulse();
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        for (int r = 0; r < 4; r++) begin
            i_read = 1'b1;
            d_read = 1'b1;
            tick();
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== (first_i ? 28'h0000100 : 28'h0000200)) begin
                failures++;
                $display("FAIL tie_first_%0d: got rd=%b addr=%h, want 1 %h", r, mem_read, mem_addr,
                         first_i ? 28'h0000100 : 28'h0000200);
            end
            mem_ready = 1'b1;
            #1;
            checks++;
            if (i_ready !== first_i || d_ready !== !first_i) begin
                failures++;
                $display("FAIL tie_ready_%0d: got ir=%b dr=%b, want %b %b", r, i_ready, d_ready, first_i, !first_i);
            end
            tick();
            mem_ready = 1'b0;
            if (first_i) i_read = 1'b0; else d_read = 1'b0;
            checks++;
            if (mem_read !== 1'b0) begin
                failures++;
                $display("FAIL tie_gap_%0d: got mem_read=%b, want 0", r, mem_read);
            end
            tick();
            checks++;
            if (mem_read !== 1'b1 || mem_addr !== (first_i ? 28'h0000200 : 28'h0000100)) begin
                failures++;
                $display("FAIL tie_second_%0d: got rd=%b addr=%h, want 1 %h", r, mem_read, mem_addr,
                         first_i ? 28'h0000200 : 28'h0000100);
            end
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            i_read = 1'b0;
            d_read = 1'b0;
            checks++;
            if (mem_read !== 1'b0) begin
                failures++;
                $display("FAIL tie_end_%0d: got mem_read=%b, want 0", r, mem_read);
            end
        end
        checks++;
        if (i_cnt !== 2'd3 || d_cnt !== 2'd3) begin
            failures++;
            $display("FAIL tie_counts: got i=%0d d=%0d, want 3 3", i_cnt, d_cnt);
        end
    endtask

    task automatic test_back_to_back();
        rst_pulse();
        d_write = 1'b1;
        d_addr = 28'h0000020;
        d_wdata = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h0000020 ||
            mem_wdata !== 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321) begin
            failures++;
            $display("FAIL wb_write: got wr=%b rd=%b addr=%h wdata=%h, want 1 0 0000020 1234...4321",
                     mem_write, mem_read, mem_addr, mem_wdata);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL wb_ready: got dr=%b ir=%b, want 1 0", d_ready, i_ready);
        end
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
        d_read = 1'b1;
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL wb_gap: got wr=%b rd=%b, want 0 0", mem_write, mem_read);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000020) begin
            failures++;
            $display("FAIL wb_alloc: got rd=%b wr=%b addr=%h, want 1 0 0000020", mem_read, mem_write, mem_addr);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        d_read = 1'b0;
        checks++;
        if (d_cnt !== 2'd2 || i_cnt !== 2'd0) begin
            failures++;
            $display("FAIL wb_counts: got d=%0d i=%0d, want 2 0", d_cnt, i_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rst_pulse();
        d_read = 1'b1;
        d_addr = 28'h0000030;
        tick();
        tick();
        tick();
        proc_reset = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL rstmid_drop: got rd=%b addr=%h, want 0 0", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready_in_reset: got d_ready=%b, want 0", d_ready);
        end
        tick();
        proc_reset = 1'b0;
        d_read = 1'b0;
        #1;
        checks++;
        if (d_ready !== 1'b0 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready_idle: got dr=%b ir=%b, want 0 0", d_ready, i_ready);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (d_cnt !== 2'd0 || i_cnt !== 2'd0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: got d=%0d i=%0d rd=%b, want 0 0 0", d_cnt, i_cnt, mem_read);
        end
    endtask

    task automatic test_violation();
        rst_pulse();
        i_read = 1'b1;
        i_addr = 28'h0000040;
        tick();
        d_read = 1'b1;
        d_addr = 28'h0000050;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000040) begin
            failures++;
            $display("FAIL viol_grant_i: got rd=%b addr=%h, want 1 0000040", mem_read, mem_addr);
        end
        tick();
        i_read = 1'b0;
        tick();
        checks++;
        if (mem_read !== 1'b0 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL viol_idle: got rd=%b ir=%b, want 0 0", mem_read, i_ready);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000050) begin
            failures++;
            $display("FAIL viol_grant_d: got rd=%b addr=%h, want 1 0000050", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            failures++;
            $display("FAIL viol_ready: got dr=%b ir=%b, want 1 0", d_ready, i_ready);
        end
        tick();
        mem_ready = 1'b0;
        d_read = 1'b0;
        checks++;
        if (i_cnt !== 2'd0 || d_cnt !== 2'd1) begin
            failures++;
            $display("FAIL viol_counts: got i=%0d d=%0d, want 0 1", i_cnt, d_cnt);
        end
    endtask

    task automatic test_saturate();
        rst_pulse();
        d_addr = 28'h0000060;
        for (int k = 1; k <= 5; k++) begin
            d_read = 1'b1;
            tick();
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            d_read = 1'b0;
            tick();
            checks++;
            if (d_cnt !== 2'(k > 3 ? 3 : k)) begin
                failures++;
                $display("FAIL sat_%0d: got d_cnt=%0d, want %0d", k, d_cnt, k > 3 ? 3 : k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_violation();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
